// File: rtl/ws2811_rx.sv
// WS2811 single-wire LED protocol receiver: decodes high-pulse widths into
// 24-bit GRB pixels, reporting pixel index, latch (long low) and framing errors.
module ws2811_rx #(
    parameter int T_MIN_HIGH = 8,
    parameter int T_THRESH   = 42,
    parameter int T_MAX_HIGH = 100,
    parameter int T_LATCH    = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [9:0]  pixel_index,
    output logic        latch,
    output logic        frame_error
);
    typedef enum logic [1:0] {WAIT_LATCH, IDLE, HIGH, LOW} state_e;

    localparam logic [11:0] LATCH_CNT  = 12'(T_LATCH);
    localparam logic [7:0]  MIN_CNT    = 8'(T_MIN_HIGH);
    localparam logic [7:0]  THRESH_CNT = 8'(T_THRESH);
    localparam logic [7:0]  ERR_CNT    = 8'(T_MAX_HIGH + 1);

    logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    state_e      state_q, state_d;
    logic [11:0] low_cnt_q, low_cnt_d;
    logic [7:0]  high_cnt_q, high_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [9:0]  pix_cnt_q, pix_cnt_d;
    logic [23:0] pixel_data_q, pixel_data_d;
    logic [9:0]  pixel_index_q, pixel_index_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        latch_q, latch_d;
    logic        frame_error_q, frame_error_d;

    logic        line, rise, latch_hit;
    logic [11:0] low_inc;
    logic [7:0]  high_inc;
    logic [4:0]  bit_inc;

    assign line     = sync2_q;
    assign rise     = sync2_q & ~prev_q;
    assign low_inc  = (low_cnt_q == 12'hFFF) ? low_cnt_q : low_cnt_q + 12'd1;
    assign high_inc = (high_cnt_q == 8'hFF) ? high_cnt_q : high_cnt_q + 8'd1;
    assign bit_inc  = (bit_cnt_q == 5'h1F) ? bit_cnt_q : bit_cnt_q + 5'd1;

    always_comb begin
        sync1_d       = din;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        high_cnt_d    = high_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        pix_cnt_d     = pix_cnt_q;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        pixel_valid_d = 1'b0;
        latch_d       = 1'b0;
        frame_error_d = 1'b0;
        latch_hit     = 1'b0;

        if (bit_cnt_q == 5'd24) begin
            pixel_valid_d = 1'b1;
            pixel_data_d  = shift_q;
            pixel_index_d = pix_cnt_q;
            bit_cnt_d     = '0;
            pix_cnt_d     = (pix_cnt_q == 10'h3FF) ? pix_cnt_q : pix_cnt_q + 10'd1;
        end

        case (state_q)
            WAIT_LATCH: begin
                low_cnt_d = line ? 12'd0 : low_inc;
                latch_hit = !line && (low_inc == LATCH_CNT);
            end
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = 8'd1;
                end
            end
            HIGH: begin
                if (line) begin
                    high_cnt_d = high_inc;
                    if (high_inc == ERR_CNT) begin
                        frame_error_d = 1'b1;
                        bit_cnt_d     = '0;
                        shift_d       = '0;
                        low_cnt_d     = '0;
                        state_d       = WAIT_LATCH;
                    end
                end else if (high_cnt_q < MIN_CNT) begin
                    // Glitch: resume the interrupted low period; a zero low count
                    // means we came from IDLE, which never counts low time.
                    if (low_cnt_q == 12'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = LOW;
                        low_cnt_d = low_inc;
                        latch_hit = (low_inc == LATCH_CNT);
                    end
                end else begin
                    shift_d   = {shift_q[22:0], (high_cnt_q >= THRESH_CNT)};
                    bit_cnt_d = bit_inc;
                    low_cnt_d = 12'd1;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = 8'd1;
                end else begin
                    low_cnt_d = low_inc;
                    latch_hit = (low_inc == LATCH_CNT);
                end
            end
            default: state_d = WAIT_LATCH;
        endcase

        if (latch_hit) begin
            latch_d       = 1'b1;
            frame_error_d = (bit_cnt_q != 5'd0);
            pix_cnt_d     = '0;
            bit_cnt_d     = '0;
            shift_d       = '0;
            low_cnt_d     = '0;
            state_d       = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            state_q       <= WAIT_LATCH;
            low_cnt_q     <= '0;
            high_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            pix_cnt_q     <= '0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            pixel_valid_q <= 1'b0;
            latch_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            high_cnt_q    <= high_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            pix_cnt_q     <= pix_cnt_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
            latch_q       <= latch_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_index = pixel_index_q;
    assign pixel_valid = pixel_valid_q;
    assign latch       = latch_q;
    assign frame_error = frame_error_q;
endmodule

// File: doc/ws2811_rx.md
WS2811_RX -- requirements
Module: ws2811_rx

Interface
REQ-001 Parameter T_MIN_HIGH, default 8: high pulses shorter than this many clk cycles are glitches.
REQ-002 Parameter T_THRESH, default 42: high width at or above this many cycles decodes as 1, below it as 0.
REQ-003 Parameter T_MAX_HIGH, default 100: high width beyond this many cycles is an error.
REQ-004 Parameter T_LATCH, default 2500: low width, in cycles, that marks a latch/reset (50 us at 50 MHz).
REQ-005 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din  input  1  asynchronous WS2811 serial line.
REQ-008 pixel_data  output  24  last complete pixel, GRB order, first received bit in bit 23.
REQ-009 pixel_valid  output  1  one-cycle pulse; pixel_data is valid in that cycle.
REQ-010 pixel_index  output  10  index of the pixel in pixel_data, counted from the last latch.
REQ-011 latch  output  1  one-cycle pulse when a low of T_LATCH cycles completes.
REQ-012 frame_error  output  1  one-cycle pulse on an over-long high or a partial pixel at latch.

Function
REQ-013 din SHALL pass through a 2-FF synchroniser; a third register gives edge detection on the synchronised line.
REQ-014 FSM states SHALL be WAIT_LATCH, IDLE, HIGH and LOW.
REQ-015 WAIT_LATCH behaviour:
- ignore all edges;
- count consecutive synchronised-low cycles, restarting the count on any high;
- at count == T_LATCH, pulse latch and go to IDLE.
REQ-016 IDLE/LOW rising edge SHALL go to HIGH with high_cnt = 1; high_cnt increments each further high cycle.
REQ-017 HIGH falling edge with high_cnt < T_MIN_HIGH SHALL go to LOW with no bit stored, and the low counter SHALL continue from its pre-glitch value.
REQ-018 HIGH falling edge with T_MIN_HIGH <= high_cnt <= T_MAX_HIGH SHALL do all of:
- shift bit (high_cnt >= T_THRESH) into a 24-bit shift register, MSB first;
- increment bit_cnt;
- go to LOW with low_cnt = 1.
REQ-019 When bit_cnt reaches 24, the following SHALL occur together:
- the next clk loads pixel_data and pulses pixel_valid, with pixel_index = current pixel counter;
- bit_cnt clears;
- the pixel counter increments, saturating at 1023.
REQ-020 Latency: pixel_valid SHALL assert exactly 3 clk cycles after the first clk edge that samples din low at the end of bit 24.
REQ-021 HIGH with high_cnt reaching T_MAX_HIGH+1 SHALL:
- pulse frame_error;
- clear bit_cnt and the shift register;
- go to WAIT_LATCH.
REQ-022 LOW with low_cnt reaching T_LATCH SHALL:
- pulse latch;
- clear the pixel counter to 0;
- if bit_cnt != 0, pulse frame_error in the same cycle and discard the partial bits;
- go to IDLE.
REQ-023 IDLE SHALL NOT count low time and SHALL NOT pulse latch again until a bit has been received.
REQ-024 Counters SHALL saturate and never wrap:
- low counter 12 bits;
- high counter 8 bits;
- bit_cnt 5 bits.
REQ-025 A glitch ending in the same cycle the low counter reaches T_LATCH SHALL yield latch; the latch takes priority.
REQ-026 pixel_data SHALL hold its value between pixel_valid pulses and SHALL change only on pixel_valid.

Reset
REQ-027 While rst is high, on each clk:
- state = WAIT_LATCH;
- pixel_data = 0, pixel_valid = 0, pixel_index = 0, latch = 0, frame_error = 0;
- all counters and the shift register = 0;
- synchroniser flops = 0.
REQ-028 rst asserted mid-pixel SHALL discard the partial pixel; no pixel_valid SHALL occur before the next latch pulse.

Verification
REQ-029 Every bench SHALL use 125-cycle bits: 1 = 60 high / 65 low, 0 = 24 high / 101 low.
REQ-030 Basic pixel: din low 2500 cycles, then 24'hFF0055 -> one latch pulse, then one pixel_valid with pixel_data = 24'hFF0055 and pixel_index = 0, 3 cycles after bit 24 falls.
REQ-031 Multi-pixel: 24'h123456 and 24'hABCDEF back-to-back, then low 2500 -> pixel_index 0 then 1, then latch; the next pixel reports index 0.
REQ-032 Glitch: a 5-cycle high pulse inside the low phase of bit 7 of 24'h00FF00 -> decoded pixel_data = 24'h00FF00, no frame_error.
REQ-033 Over-long high: din high 150 cycles mid-pixel -> frame_error exactly once, 101 high cycles after sync, no pixel_valid until a fresh latch; after latch plus a good pixel, decoding resumes.
REQ-034 Partial pixel: 12 bits, then low 2500 -> latch and frame_error in the same cycle, no pixel_valid.
REQ-035 Reset mid-pixel: rst for 1 cycle after bit 10 -> all outputs 0 and the remaining 14 bits ignored; next latch plus pixel 24'h000001 decodes correctly at index 0.
